// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word, stamps an imem
// byte address and queues the result in a 2-entry output FIFO.
module instr_encoder #(
  parameter int WIDTH     = 32,
  parameter int ADDR_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       kind,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  input  logic             addr_load,
  input  logic [WIDTH-1:0] addr_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_addr,
  output logic             err_kind,
  output logic             err_imm,
  output logic [15:0]      count
);

  localparam logic [3:0] K_LUI     = 4'd0;
  localparam logic [3:0] K_AUIPC   = 4'd1;
  localparam logic [3:0] K_JAL     = 4'd2;
  localparam logic [3:0] K_JALR    = 4'd3;
  localparam logic [3:0] K_BRANCH  = 4'd4;
  localparam logic [3:0] K_LOAD    = 4'd5;
  localparam logic [3:0] K_STORE   = 4'd6;
  localparam logic [3:0] K_OPIMM   = 4'd7;
  localparam logic [3:0] K_OP      = 4'd8;
  localparam logic [3:0] K_MISCMEM = 4'd9;
  localparam logic [3:0] K_SYSTEM  = 4'd10;

  logic [31:0]      word;
  logic             kind_ok;
  logic             imm_bad;
  logic             fit12, fit13, fit21;
  logic             acc, enq, deq;
  logic [WIDTH-1:0] mem_instr [2];
  logic [WIDTH-1:0] mem_addr [2];
  logic             rptr, wptr;
  logic [1:0]       occ;
  logic [WIDTH-1:0] addr_ctr;
  logic [WIDTH-1:0] base_al;
  logic [WIDTH-1:0] stamp;
  logic             base_unused;

  assign base_unused = ^addr_base[1:0];

  // Sign-representability: all bits above the field's sign bit equal the sign bit.
  assign fit12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fit13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fit21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    word    = 32'd0;
    kind_ok = 1'b1;
    imm_bad = 1'b0;
    case (kind)
      K_LUI: begin
        word    = {imm[31:12], rd, 7'b0110111};
        imm_bad = |imm[11:0];
      end
      K_AUIPC: begin
        word    = {imm[31:12], rd, 7'b0010111};
        imm_bad = |imm[11:0];
      end
      K_JAL: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
        imm_bad = imm[0] | ~fit21;
      end
      K_JALR: begin
        word    = {imm[11:0], rs1, funct3, rd, 7'b1100111};
        imm_bad = ~fit12;
      end
      K_BRANCH: begin
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
        imm_bad = imm[0] | ~fit13;
      end
      K_LOAD: begin
        word    = {imm[11:0], rs1, funct3, rd, 7'b0000011};
        imm_bad = ~fit12;
      end
      K_STORE: begin
        word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
        imm_bad = ~fit12;
      end
      K_OPIMM: begin
        word    = {imm[11:0], rs1, funct3, rd, 7'b0010011};
        imm_bad = ~fit12;
      end
      K_OP: begin
        word    = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
      end
      K_MISCMEM: begin
        word    = {imm[11:0], rs1, funct3, rd, 7'b0001111};
        imm_bad = ~fit12;
      end
      K_SYSTEM: begin
        word    = {imm[11:0], rs1, funct3, rd, 7'b1110011};
        imm_bad = ~fit12;
      end
      default: kind_ok = 1'b0;
    endcase
  end

  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign out_instr = mem_instr[rptr];
  assign out_addr  = mem_addr[rptr];

  assign acc     = in_valid && in_ready;
  assign enq     = acc && kind_ok;
  assign deq     = out_valid && out_ready;
  assign base_al = {addr_base[WIDTH-1:2], 2'b00};
  assign stamp   = addr_load ? base_al : addr_ctr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_instr[0] <= '0;
      mem_instr[1] <= '0;
      mem_addr[0]  <= '0;
      mem_addr[1]  <= '0;
      rptr         <= 1'b0;
      wptr         <= 1'b0;
      occ          <= 2'd0;
      addr_ctr     <= '0;
      count        <= 16'd0;
      err_kind     <= 1'b0;
      err_imm      <= 1'b0;
    end else begin
      if (enq) begin
        mem_instr[wptr] <= word;
        mem_addr[wptr]  <= stamp;
        wptr            <= ~wptr;
        addr_ctr        <= stamp + WIDTH'(ADDR_STEP);
      end else if (addr_load) begin
        addr_ctr <= base_al;
      end
      if (deq) begin
        rptr  <= ~rptr;
        count <= count + 16'd1;
      end
      // Simultaneous enqueue and dequeue leaves occupancy unchanged.
      if (enq && !deq)      occ <= occ + 2'd1;
      else if (!enq && deq) occ <= occ - 2'd1;
      if (acc && !kind_ok)       err_kind <= 1'b1;
      if (acc && kind_ok && imm_bad) err_imm <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table plus scoreboard of expected
// (word, address) pairs, with directed backpressure, address-load and reset sequences.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  kind = 4'd0;
  logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [6:0]  funct7 = 7'd0;
  logic [31:0] imm = 32'd0;
  logic        addr_load = 1'b0;
  logic [31:0] addr_base = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_addr;
  logic        err_kind, err_imm;
  logic [15:0] count;

  instr_encoder #(.WIDTH(32), .ADDR_STEP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .kind(kind), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .addr_load(addr_load), .addr_base(addr_base),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err_kind(err_kind), .err_imm(err_imm), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [63:0] q[$];
  logic [31:0] addr_m = 32'd0;
  int n_pushed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Output monitor: a transfer sampled here completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got instr 0x%08h addr 0x%08h with nothing expected",
                 out_instr, out_addr);
      end else begin
        logic [63:0] e;
        e = q.pop_front();
        if ({out_instr, out_addr} !== e) begin
          errors++;
          $display("FAIL out_word: got instr 0x%08h addr 0x%08h expected instr 0x%08h addr 0x%08h",
                   out_instr, out_addr, e[63:32], e[31:0]);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input vec_t v, input bit push, input bit load, input logic [31:0] base);
    bit acc;
    int n;
    kind = v.kind; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    funct3 = v.f3; funct7 = v.f7; imm = v.imm;
    addr_load = load; addr_base = base; in_valid = 1'b1;
    acc = 1'b0; n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    in_valid = 1'b0; addr_load = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: in_ready never 1 for kind %0d", v.kind);
    end else begin
      if (load) addr_m = {base[31:2], 2'b00};
      if (push) begin
        q.push_back({v.exp, addr_m});
        addr_m = addr_m + 32'd4;
        n_pushed++;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", q.size());
    end
  endtask

  // Asserts reset between edges and checks the asynchronous clear before any edge.
  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_count", {16'd0, count}, 32'd0);
    chk("rst_err_kind", {31'd0, err_kind}, 32'd0);
    chk("rst_err_imm", {31'd0, err_imm}, 32'd0);
    q.delete();
    addr_m = 32'd0;
    n_pushed = 0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t tbl[6];
  vec_t w1, w2, w3, bad, jal3;

  initial begin
    tbl[0] = '{4'd0,  5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h12345137}; // LUI
    tbl[1] = '{4'd2,  5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8,        32'h008000EF}; // JAL
    tbl[2] = '{4'd4,  5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd16,       32'h00208863}; // BRANCH
    tbl[3] = '{4'd6,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4,        32'h0020A223}; // STORE
    tbl[4] = '{4'd8,  5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,        32'h002081B3}; // OP add
    tbl[5] = '{4'd3,  5'd1, 5'd5, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFFC280E7}; // JALR -4

    #2;
    chk("por_out_valid", {31'd0, out_valid}, 32'd0);
    chk("por_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Test 1: single-cycle latency into an empty FIFO
    out_ready = 1'b0;
    w1 = '{4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093};
    send(w1, 1'b1, 1'b0, 32'd0);
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_out_instr", out_instr, 32'h00500093);
    chk("t1_out_addr", out_addr, 32'd0);
    out_ready = 1'b1;
    drain();
    chk("t1_count", {16'd0, count}, 32'd1);

    // Tests 2/3: vector table with output always ready
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send(tbl[i], 1'b1, 1'b0, 32'd0);
    drain();
    chk("t2_count", {16'd0, count}, 32'(n_pushed));
    chk("t2_err_imm", {31'd0, err_imm}, 32'd0);
    chk("t2_err_kind", {31'd0, err_kind}, 32'd0);

    // Test 4: backpressure, FIFO full, stable outputs, order preserved
    out_ready = 1'b0;
    w1 = tbl[4];
    w2 = tbl[0];
    w3 = tbl[3];
    send(w1, 1'b1, 1'b0, 32'd0);
    send(w2, 1'b1, 1'b0, 32'd0);
    chk("t4_in_ready_full", {31'd0, in_ready}, 32'd0);
    fork
      send(w3, 1'b1, 1'b0, 32'd0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("t4_hold_instr", out_instr, 32'h002081B3);
          chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();

    // Test 5: addr_load with accept, load alone, and counter wrap
    send(tbl[1], 1'b1, 1'b1, 32'h00000103);
    send(tbl[2], 1'b1, 1'b0, 32'd0);
    addr_load = 1'b1; addr_base = 32'h00000020;
    @(posedge clk); #1 addr_load = 1'b0;
    addr_m = 32'h00000020;
    send(tbl[4], 1'b1, 1'b0, 32'd0);
    send(tbl[5], 1'b1, 1'b1, 32'hFFFFFFFC);
    send(tbl[3], 1'b1, 1'b0, 32'd0);
    drain();
    chk("t5_wrap_model", addr_m, 32'd4);

    // Test 6: undefined kind dropped, misaligned JAL flagged, async reset mid-stream
    bad = '{4'hF, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 32'd0};
    send(bad, 1'b0, 1'b0, 32'd0);
    chk("t6_err_kind", {31'd0, err_kind}, 32'd1);
    chk("t6_no_output", {31'd0, out_valid}, 32'd0);
    jal3 = '{4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h002000EF};
    send(jal3, 1'b1, 1'b0, 32'd0);
    chk("t6_err_imm", {31'd0, err_imm}, 32'd1);
    drain();
    out_ready = 1'b0;
    send(tbl[0], 1'b1, 1'b0, 32'd0);
    send(tbl[1], 1'b1, 1'b0, 32'd0);
    do_reset();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("t6_discarded", {31'd0, out_valid}, 32'd0);

    // Immediate range boundaries
    w1 = '{4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h80000093};
    send(w1, 1'b1, 1'b0, 32'd0);
    drain();
    chk("imm_i_2048", {31'd0, err_imm}, 32'd1);
    do_reset();
    out_ready = 1'b1;
    w1 = '{4'd0, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h12345137};
    send(w1, 1'b1, 1'b0, 32'd0);
    drain();
    chk("imm_lui_low", {31'd0, err_imm}, 32'd1);
    do_reset();
    out_ready = 1'b1;
    w1 = '{4'd6, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFFF800, 32'h8020A023};
    send(w1, 1'b1, 1'b0, 32'd0);
    drain();
    chk("imm_s_min", {31'd0, err_imm}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, instruction and address width; only 32 is supported.
REQ-002 SHALL have parameter ADDR_STEP, default 4, byte increment of the address counter per accepted instruction.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  field set presented.
REQ-006 in_ready  output  1  encoder can accept this cycle.
REQ-007 kind  input  4  instruction class, same constants as the processor decoder: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, MISCMEM, SYSTEM.
REQ-008 rd, rs1, rs2  input  5 each  register fields.
REQ-009 funct3  input  3; funct7  input  7  function fields.
REQ-010 imm  input  32  full decoded immediate value, same form the decoder produces.
REQ-011 addr_load  input  1; addr_base  input  WIDTH  load the address counter.
REQ-012 out_valid  output  1; out_ready  input  1  output handshake.
REQ-013 out_instr  output  WIDTH; out_addr  output  WIDTH  encoded word and its imem byte address.
REQ-014 err_kind, err_imm  output  1 each  sticky error flags.
REQ-015 count  output  16  number of words delivered on the output, wrapping.

Function
REQ-016 A transfer SHALL occur on an input edge where in_valid&&in_ready, and on an output edge where out_valid&&out_ready.
REQ-017 Accepted words SHALL enter a 2-entry FIFO; in_ready SHALL be 1 whenever fewer than 2 entries are held and SHALL be driven from registered state only.
REQ-018 Latency SHALL be 1 cycle: a word accepted at edge N SHALL be visible with out_valid=1 after edge N when the FIFO was empty.
REQ-019 out_instr/out_addr SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 A simultaneous accept and deliver with 2 entries held is impossible because in_ready=0; with 1 entry held, occupancy SHALL stay 1 and order SHALL be preserved.
REQ-021 Encoding SHALL follow RV32I formats with opcode[6:0] set by kind: R (OP) = funct7,rs2,rs1,funct3,rd.
REQ-022 I (JALR, LOAD, OPIMM, MISCMEM, SYSTEM) SHALL use imm[11:0],rs1,funct3,rd; OPIMM shifts carry funct7 in imm[11:5] supplied by the caller.
REQ-023 S (STORE) SHALL use imm[11:5],rs2,rs1,funct3,imm[4:0].
REQ-024 B (BRANCH) SHALL use imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11].
REQ-025 U (LUI, AUIPC) SHALL use imm[31:12],rd.
REQ-026 J (JAL) SHALL use imm[20],imm[10:1],imm[11],imm[19:12],rd.
REQ-027 An accepted word with an undefined kind SHALL NOT be enqueued and SHALL NOT advance the address counter, and SHALL set err_kind.
REQ-028 err_imm SHALL be set on accept when any of these hold, with the word still encoded from the in-format bits: BRANCH/JAL with imm[0]=1; LUI/AUIPC with imm[11:0]!=0; I/S/B/J immediate not sign-representable in the field width.
REQ-029 The address counter SHALL stamp each enqueued word, then advance by ADDR_STEP, wrapping modulo 2^32.
REQ-030 addr_load SHALL set the counter to {addr_base[31:2],2'b00}.
REQ-031 If addr_load coincides with an enqueue, the word SHALL take the new base and the counter SHALL become base+ADDR_STEP.
REQ-032 count SHALL increment per output transfer, wrapping 0xFFFF->0.

Reset
REQ-033 On rst high, immediately and asynchronously: FIFO empty, out_valid=0, in_ready=1, counter=0, count=0, err_kind=0, err_imm=0, out_instr=0, out_addr=0.
REQ-034 rst mid-operation SHALL discard held words without delivering them; the error flags SHALL clear only on reset.

Verification
REQ-035 Test 1: after reset, send OPIMM rd=1 rs1=0 f3=0 imm=5. Require next cycle out_instr=0x00500093 and out_addr=0.
REQ-036 Test 2: send LUI rd=2 imm=0x12345000, then JAL rd=1 imm=8, with out_ready=1. Require 0x12345137 @0, then 0x008000EF @4, and count=2.
REQ-037 Test 3: send BRANCH f3=0 rs1=1 rs2=2 imm=16, then STORE f3=2 rs1=1 rs2=2 imm=4. Require 0x00208863, then 0x0020A223.
REQ-038 Test 4: hold out_ready=0 and send 3 words. Require in_ready=0 after 2 accepts and outputs stable; release and require FIFO order.
REQ-039 Test 5: addr_load base=0x103 together with an accept. Require out_addr=0x100 and next word address 0x104; counter at 0xFFFFFFFC wraps to 0.
REQ-040 Test 6: send kind=4'hF, then JAL imm=3. Require the first is not emitted with err_kind=1; require err_imm=1; assert rst mid-stream and require flags/out_valid=0 with no clock edge.
